// File: rtl/button_conditioner_if.sv
// Button bundle between the raw pins and the conditioned outputs.
// The master drives btn_raw and reads the conditioned outputs; the slave is the conditioner.
interface button_conditioner_if #(
    parameter int N_CH = 5
);
    logic [N_CH-1:0] btn_raw;
    logic [N_CH-1:0] btn_level;
    logic [N_CH-1:0] btn_press;
    logic [N_CH-1:0] btn_release;
    logic [N_CH-1:0] btn_long;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_long
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_long
    );
endinterface

// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: per-channel synchroniser, debounce FSM,
// debounced level, press/release pulses and a one-shot long-press pulse.
module button_conditioner #(
    parameter int N_CH            = 5,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 100_000_000,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic                fpga_clk,
    input  logic                rst_n,
    button_conditioner_if.slave btn
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int LC_W  = $clog2(LONG_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LC_W-1:0]  LC_MAX  = LC_W'(LONG_CYCLES);
    localparam logic [LC_W-1:0]  LC_PRE  = LC_W'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_e;

    // Reset asserts asynchronously but is released in step with fpga_clk.
    logic [1:0] rst_pipe_q;
    logic [1:0] rst_pipe_d;
    logic       rst_sync_n;

    always_comb begin
        rst_pipe_d = {rst_pipe_q[0], 1'b1};
    end

    always_ff @(posedge fpga_clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_pipe_q <= '0;
        end else begin
            rst_pipe_q <= rst_pipe_d;
        end
    end

    assign rst_sync_n = rst_pipe_q[1];

    logic [N_CH-1:0] level_vec;
    logic [N_CH-1:0] press_vec;
    logic [N_CH-1:0] release_vec;
    logic [N_CH-1:0] long_vec;

    assign btn.btn_level   = level_vec;
    assign btn.btn_press   = press_vec;
    assign btn.btn_release = release_vec;
    assign btn.btn_long    = long_vec;

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [SYNC_STAGES-1:0] sync_d;
        state_e                 state_q;
        state_e                 state_d;
        logic [CNT_W-1:0]       cnt_q;
        logic [CNT_W-1:0]       cnt_d;
        logic [LC_W-1:0]        lc_q;
        logic [LC_W-1:0]        lc_d;
        logic                   level_q;
        logic                   level_d;
        logic                   press_q;
        logic                   press_d;
        logic                   rel_q;
        logic                   rel_d;
        logic                   long_q;
        logic                   long_d;
        logic                   raw_in;
        logic                   s;

        assign raw_in = ACTIVE_LOW ? ~btn.btn_raw[ch] : btn.btn_raw[ch];
        assign s      = sync_q[SYNC_STAGES-1];

        always_comb begin
            sync_d  = {sync_q[SYNC_STAGES-2:0], raw_in};
            state_d = state_q;
            cnt_d   = cnt_q;
            lc_d    = lc_q;
            level_d = level_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            long_d  = 1'b0;

            case (state_q)
                IDLE: begin
                    if (s) begin
                        state_d = PRESS_WAIT;
                        cnt_d   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state_d = IDLE;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = HELD;
                        level_d = 1'b1;
                        press_d = 1'b1;
                        lc_d    = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                HELD: begin
                    // lc saturates at LONG_CYCLES, so the long pulse fires once per hold
                    if (lc_q < LC_MAX) begin
                        lc_d   = lc_q + 1'b1;
                        long_d = (lc_q == LC_PRE);
                    end
                    if (!s) begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (s) begin
                        state_d = HELD;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = IDLE;
                        level_d = 1'b0;
                        rel_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        always_ff @(posedge fpga_clk or negedge rst_sync_n) begin
            if (!rst_sync_n) begin
                sync_q  <= '0;
                state_q <= IDLE;
                cnt_q   <= '0;
                lc_q    <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                long_q  <= 1'b0;
            end else begin
                sync_q  <= sync_d;
                state_q <= state_d;
                cnt_q   <= cnt_d;
                lc_q    <= lc_d;
                level_q <= level_d;
                press_q <= press_d;
                rel_q   <= rel_d;
                long_q  <= long_d;
            end
        end

        assign level_vec[ch]   = level_q;
        assign press_vec[ch]   = press_q;
        assign release_vec[ch] = rel_q;
        assign long_vec[ch]    = long_q;
    end

endmodule
